cp0: RTL and testbench
======================

# cp0

Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline. Holds SR, Cause, EPC and PRId and arbitrates hardware interrupts against synchronous exceptions reported from the M stage. Raises a one-cycle entry request that makes the pipeline redirect to the handler and squash younger stages. On `eret` it supplies EPC as the return target; `eret_d` drives the D-stage NOP insertion.

## Interface
Parameters:
- `PRID`, 32'h0000_0D00, read-only processor ID value.
- `HANDLER`, 32'h0000_4180, exception vector, exported for the PC mux.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `a1`  in  5  `mfc0` read register number.
- `a2`  in  5  `mtc0` write register number.
- `din`  in  32  `mtc0` write data.
- `we`  in  1  `mtc0` write enable (M stage).
- `pc`  in  32  PC of the M-stage instruction.
- `exc_code`  in  5  M-stage exception code; 0 means no exception.
- `bd`  in  1  M-stage instruction sits in a branch delay slot.
- `hw_int`  in  6  external interrupt lines [7:2], level-sensitive.
- `exl_clr`  in  1  `eret` in M stage.
- `intreq`  out  1  exception/interrupt entry this cycle.
- `epc`  out  32  current EPC, the `eret` target.
- `dout`  out  32  `mfc0` read data.

## Operation
- SR fields: IM[15:10], EXL[1], IE[0]. All other bits read as 0.
- Cause fields: BD[31], IP[15:10], ExcCode[6:2]. All other bits read as 0.
- EPC[31:2] is writable. EPC[1:0] always reads 0.
- `int_hit` = |(hw_int & IM) & IE & !EXL.
- `exc_hit` = (exc_code != 0) & !EXL.
- `intreq` = `int_hit` | `exc_hit`. It is combinational.
- On an `intreq` edge:
  - EXL <= 1.
  - ExcCode <= 0 if `int_hit`, otherwise `exc_code`. Interrupt wins when both hit.
  - BD <= `bd`.
  - EPC <= `bd` ? `pc`-4 : `pc`, with bits [1:0] forced to 0.
- Cause.IP <= `hw_int` on every edge, unconditionally.
- `mtc0` (`we`): writes to 12 (SR) and 14 (EPC) take effect. Writes to 13 (Cause), 15 (PRId) and other numbers are ignored.
- An `mtc0` in the same cycle as `intreq` is discarded; the entry update wins.
- `exl_clr`: EXL <= 0 on the edge.
- `exl_clr` and `intreq` in the same cycle: entry wins and EXL stays 1. `intreq` is unreachable in that case whenever EXL was already 1.
- `dout`: combinational on `a1` for registers 12–15. Other register numbers read 0.

## Timing
- Reset values:
  - SR = 0, Cause = 0, EPC = 0.
  - `intreq` = 0, `epc` = 0, `dout` = 0 for any readable address except 15, which returns PRID.
- `intreq` is valid in the same cycle as its inputs. The register update takes effect at the next rising edge.
- `mfc0` sees an `mtc0` one cycle after the write edge. There is no internal bypass; the hazard unit stalls.
- Back-to-back entries are impossible: EXL masks both hit terms from the next cycle.
- Reset asserted mid-handler clears EXL immediately, with no clock edge required.

## Configuration
- `CP0_BD_EN` defined:
  - Cause.BD is implemented.
  - EPC is adjusted by -4 for delay-slot instructions.
- `CP0_BD_EN` undefined:
  - `bd` input is ignored.
  - Cause.BD reads 0.
  - EPC <= `pc` always.

## Structure
- Shared package `cp0_pkg` holds:
  - Register numbers SR=12, CAUSE=13, EPC=14, PRID=15.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
  - Handler address constant.
  - SR/Cause bit-position constants.
- Sub-module `cp0_int_arb`: combinational; computes `int_hit`, `exc_hit`, `intreq` and the selected ExcCode. Register state stays in `cp0`.

## Test plan
- Reset, then read a1=15 -> `dout`=32'h0000_0D00; a1=12,13,14 -> 0.
- `mtc0` SR=32'h0000_0401, hw_int=6'b000001, pc=32'h0000_3008 -> `intreq`=1; next cycle EXL=1, ExcCode=0, EPC=32'h0000_3008, `intreq`=0.
- exc_code=12 (Ov), bd=1, pc=32'h0000_3010 with EXL=0 -> EPC=32'h0000_300C, BD=1, ExcCode=12. With `CP0_BD_EN` undefined -> EPC=32'h0000_3010, BD=0.
- Interrupt and exc_code=10 in the same cycle -> ExcCode=0. The concurrent `mtc0` to EPC of 32'hFFFF_FFFF is discarded.
- EXL=1, exl_clr=1 -> EXL=0 next cycle. A pending interrupt then fires `intreq` in the following cycle.
- Assert reset asynchronously mid-cycle while EXL=1 -> SR and EPC read 0 before the next clock edge.

Source files
------------

// File: rtl/cp0_pkg.sv
// cp0_pkg: constants shared by the CP0 exception/interrupt controller.
//   - CP0 register numbers (SR, Cause, EPC, PRId)
//   - ExcCode values, default handler vector and PRId
//   - SR / Cause bit positions
//   - epc_target(): return address for an exception entry
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
    localparam logic [31:0] PRID_DEFAULT = 32'h0000_0D00;

    // SR fields
    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int SR_IM_LO = 10;
    // Cause fields
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_BD     = 31;

    // A delay-slot instruction restarts at its branch, one word earlier.
    // Only the word address is kept; EPC[1:0] are hardwired to zero.
    function automatic logic [29:0] epc_target(input logic [31:0] pc, input logic bd);
        logic [31:0] t;
        t = bd ? (pc - 32'd4) : pc;
        return t[31:2];
    endfunction

endpackage

// File: rtl/cp0_if.sv
// cp0_if: pipeline <-> CP0 bus.
//   master (pipeline): drives mfc0/mtc0 fields, M-stage exception info,
//                      hw_int and exl_clr; receives intreq, epc, dout.
//   slave  (cp0)     : the reverse.
interface cp0_if;
    logic [4:0]  a1;        // mfc0 register number
    logic [4:0]  a2;        // mtc0 register number
    logic [31:0] din;       // mtc0 data
    logic        we;        // mtc0 write enable
    logic [31:0] pc;        // M-stage PC
    logic [4:0]  exc_code;  // M-stage exception code, 0 = none
    logic        bd;        // M-stage instruction is in a delay slot
    logic [5:0]  hw_int;    // external interrupt lines [7:2]
    logic        exl_clr;   // eret in M stage
    logic        intreq;    // exception/interrupt entry this cycle
    logic [31:0] epc;       // eret target
    logic [31:0] dout;      // mfc0 data

    modport master (
        output a1, a2, din, we, pc, exc_code, bd, hw_int, exl_clr,
        input  intreq, epc, dout
    );
    modport slave (
        input  a1, a2, din, we, pc, exc_code, bd, hw_int, exl_clr,
        output intreq, epc, dout
    );
endinterface

// File: rtl/cp0_int_arb.sv
// cp0_int_arb: combinational entry arbitration.
//   in : hw_int, im, ie, exl, exc_code
//   out: int_hit, exc_hit, intreq, exc_sel (ExcCode to latch on entry)
// EXL masks both sources, so an entry can never follow an entry.
module cp0_int_arb
    import cp0_pkg::*;
(
    input  logic [5:0] hw_int_i,
    input  logic [5:0] im_i,
    input  logic       ie_i,
    input  logic       exl_i,
    input  logic [4:0] exc_code_i,
    output logic       int_hit_o,
    output logic       exc_hit_o,
    output logic       intreq_o,
    output logic [4:0] exc_sel_o
);
    assign int_hit_o = (|(hw_int_i & im_i)) & ie_i & ~exl_i;
    assign exc_hit_o = (exc_code_i != 5'd0) & ~exl_i;
    assign intreq_o  = int_hit_o | exc_hit_o;
    // Interrupt takes priority over a concurrent synchronous exception.
    assign exc_sel_o = int_hit_o ? EXC_INT : exc_code_i;
endmodule

// File: rtl/cp0.sv
// cp0: coprocessor-0 exception/interrupt controller (SR, Cause, EPC, PRId).
//   clk, reset : clock, async active-high reset
//   bus        : cp0_if.slave -- mfc0/mtc0, M-stage exception info,
//                hw_int, eret (exl_clr); returns intreq, epc, dout
// Parameters: PRID (PRId read value), HANDLER (vector for the PC mux).
// Build option: CP0_BD_EN implements Cause.BD and the delay-slot EPC
// adjustment; when undefined, bd is ignored.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID    = PRID_DEFAULT,
    parameter logic [31:0] HANDLER = HANDLER_ADDR
)(
    input  logic  clk,
    input  logic  reset,
    cp0_if.slave  bus
);
    logic [5:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic        exl_q, exl_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [29:0] epc_q, epc_d;

    logic        int_hit, exc_hit, intreq;
    logic [4:0]  exc_sel;
    logic        bd_eff;
    logic [31:0] sr_rd, cause_rd;

`ifdef CP0_BD_EN
    assign bd_eff = bus.bd;
`else
    assign bd_eff = 1'b0;
`endif

    cp0_int_arb u_arb (
        .hw_int_i   (bus.hw_int),
        .im_i       (im_q),
        .ie_i       (ie_q),
        .exl_i      (exl_q),
        .exc_code_i (bus.exc_code),
        .int_hit_o  (int_hit),
        .exc_hit_o  (exc_hit),
        .intreq_o   (intreq),
        .exc_sel_o  (exc_sel)
    );

    always_comb begin
        im_d      = im_q;
        ie_d      = ie_q;
        exl_d     = exl_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        ip_d      = bus.hw_int;   // pending lines are sampled every cycle
        if (intreq) begin
            // Entry overrides any mtc0 or eret in the same cycle.
            exl_d     = 1'b1;
            exccode_d = exc_sel;
            bd_d      = bd_eff;
            epc_d     = epc_target(bus.pc, bd_eff);
        end else begin
            if (bus.we) begin
                case (bus.a2)
                    REG_SR: begin
                        im_d  = bus.din[SR_IM_LO +: 6];
                        exl_d = bus.din[SR_EXL];
                        ie_d  = bus.din[SR_IE];
                    end
                    REG_EPC: epc_d = bus.din[31:2];
                    default: ;    // Cause, PRId and others are read-only
                endcase
            end
            if (bus.exl_clr) exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q      <= '0;
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= '0;
            exccode_q <= '0;
            epc_q     <= '0;
        end else begin
            im_q      <= im_d;
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        sr_rd                          = '0;
        sr_rd[SR_IM_LO +: 6]           = im_q;
        sr_rd[SR_EXL]                  = exl_q;
        sr_rd[SR_IE]                   = ie_q;
        cause_rd                       = '0;
        cause_rd[CAUSE_BD]             = bd_q;
        cause_rd[CAUSE_IP_LO +: 6]     = ip_q;
        cause_rd[CAUSE_EXC_LO +: 5]    = exccode_q;
    end

    always_comb begin
        case (bus.a1)
            REG_SR:    bus.dout = sr_rd;
            REG_CAUSE: bus.dout = cause_rd;
            REG_EPC:   bus.dout = {epc_q, 2'b00};
            REG_PRID:  bus.dout = PRID;
            default:   bus.dout = '0;
        endcase
    end

    assign bus.intreq = intreq;
    assign bus.epc    = {epc_q, 2'b00};

    // pc[1:0] never reach EPC; HANDLER is consumed by the PC mux outside.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.pc[1:0], bus.bd, HANDLER, int_hit, exc_hit};
endmodule

// File: tb/tb_cp0.sv
// tb_cp0: scoreboard bench for cp0. Expected register values are pushed
// when stimulus is driven and popped/compared by reading them via mfc0.
module tb_cp0;
    import cp0_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cp0_if bus();
    cp0 dut (.clk(clk), .reset(reset), .bus(bus.slave));

`ifdef CP0_BD_EN
    localparam bit BD_ON = 1'b1;
`else
    localparam bit BD_ON = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [4:0]  addr;
        logic [31:0] val;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic push(input string n, input logic [4:0] a, input logic [31:0] v);
        sb_t e;
        e.name = n; e.addr = a; e.val = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we = 1'b0; bus.a2 = '0; bus.din = '0;
        bus.exc_code = '0; bus.bd = 1'b0; bus.exl_clr = 1'b0;
    endtask

    task automatic test_reset();
        sb_t e;
        push("rst_sr", REG_SR, 32'h0);
        push("rst_cause", REG_CAUSE, 32'h0);
        push("rst_epc", REG_EPC, 32'h0);
        push("rst_prid", REG_PRID, 32'h0000_0D00);
        push("rst_r0", 5'd0, 32'h0);
        n_cmp++;
        if (bus.intreq !== 1'b0) begin
            n_err++; $display("FAIL rst_intreq: got %b expected 0", bus.intreq);
        end
        n_cmp++;
        if (bus.epc !== 32'h0) begin
            n_err++; $display("FAIL rst_epc_port: got %h expected 0", bus.epc);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus.a1 = e.addr; #1; n_cmp++;
            if (bus.dout !== e.val) begin
                n_err++; $display("FAIL %s: got %h expected %h", e.name, bus.dout, e.val);
            end
        end
    endtask

    task automatic test_interrupt();
        sb_t e;
        bus.we = 1'b1; bus.a2 = REG_SR; bus.din = 32'h0000_0401;
        tick();
        idle();
        bus.hw_int = 6'b000001; bus.pc = 32'h0000_3008;
        #1; n_cmp++;
        if (bus.intreq !== 1'b1) begin
            n_err++; $display("FAIL int_req: got %b expected 1", bus.intreq);
        end
        push("int_sr", REG_SR, 32'h0000_0403);
        push("int_cause", REG_CAUSE, 32'h0000_0400);
        push("int_epc", REG_EPC, 32'h0000_3008);
        tick();
        n_cmp++;
        if (bus.intreq !== 1'b0) begin
            n_err++; $display("FAIL int_masked: got %b expected 0", bus.intreq);
        end
        n_cmp++;
        if (bus.epc !== 32'h0000_3008) begin
            n_err++; $display("FAIL int_epc_port: got %h expected 00003008", bus.epc);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus.a1 = e.addr; #1; n_cmp++;
            if (bus.dout !== e.val) begin
                n_err++; $display("FAIL %s: got %h expected %h", e.name, bus.dout, e.val);
            end
        end
        bus.hw_int = 6'b0;
        tick();
    endtask

    task automatic test_exc_bd();
        sb_t e;
        bus.exl_clr = 1'b1;
        tick();
        idle();
        bus.exc_code = EXC_OV; bus.bd = 1'b1; bus.pc = 32'h0000_3010;
        #1; n_cmp++;
        if (bus.intreq !== 1'b1) begin
            n_err++; $display("FAIL exc_req: got %b expected 1", bus.intreq);
        end
        push("exc_sr", REG_SR, 32'h0000_0403);
        push("exc_cause", REG_CAUSE, BD_ON ? 32'h8000_0030 : 32'h0000_0030);
        push("exc_epc", REG_EPC, BD_ON ? 32'h0000_300C : 32'h0000_3010);
        tick();
        idle();
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus.a1 = e.addr; #1; n_cmp++;
            if (bus.dout !== e.val) begin
                n_err++; $display("FAIL %s: got %h expected %h", e.name, bus.dout, e.val);
            end
        end
    endtask

    // Interrupt + RI + mtc0 EPC + eret all in the entry cycle.
    task automatic test_collision();
        sb_t e;
        bus.exl_clr = 1'b1;
        tick();
        idle();
        bus.hw_int = 6'b000001; bus.exc_code = EXC_RI; bus.pc = 32'h0000_3020;
        bus.we = 1'b1; bus.a2 = REG_EPC; bus.din = 32'hFFFF_FFFF; bus.exl_clr = 1'b1;
        #1; n_cmp++;
        if (bus.intreq !== 1'b1) begin
            n_err++; $display("FAIL col_req: got %b expected 1", bus.intreq);
        end
        push("col_sr", REG_SR, 32'h0000_0403);
        push("col_cause", REG_CAUSE, 32'h0000_0400);
        push("col_epc", REG_EPC, 32'h0000_3020);
        tick();
        idle();
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus.a1 = e.addr; #1; n_cmp++;
            if (bus.dout !== e.val) begin
                n_err++; $display("FAIL %s: got %h expected %h", e.name, bus.dout, e.val);
            end
        end
    endtask

    // eret with an interrupt still pending: re-entry one cycle later.
    task automatic test_eret_pending();
        sb_t e;
        bus.exl_clr = 1'b1; bus.pc = 32'h0000_3040;
        #1; n_cmp++;
        if (bus.intreq !== 1'b0) begin
            n_err++; $display("FAIL eret_req_now: got %b expected 0", bus.intreq);
        end
        tick();
        bus.exl_clr = 1'b0;
        #1; n_cmp++;
        if (bus.intreq !== 1'b1) begin
            n_err++; $display("FAIL eret_refire: got %b expected 1", bus.intreq);
        end
        bus.a1 = REG_SR; #1; n_cmp++;
        if (bus.dout !== 32'h0000_0401) begin
            n_err++; $display("FAIL eret_sr_clr: got %h expected 00000401", bus.dout);
        end
        push("eret_sr", REG_SR, 32'h0000_0403);
        push("eret_epc", REG_EPC, 32'h0000_3040);
        push("eret_cause", REG_CAUSE, 32'h0000_0400);
        tick();
        bus.hw_int = 6'b0;
        #1; n_cmp++;
        if (bus.intreq !== 1'b0) begin
            n_err++; $display("FAIL eret_masked: got %b expected 0", bus.intreq);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus.a1 = e.addr; #1; n_cmp++;
            if (bus.dout !== e.val) begin
                n_err++; $display("FAIL %s: got %h expected %h", e.name, bus.dout, e.val);
            end
        end
    endtask

    task automatic test_mtc0_filter();
        sb_t e;
        bus.exl_clr = 1'b1;
        tick();
        idle();
        bus.we = 1'b1; bus.a2 = REG_CAUSE; bus.din = 32'hFFFF_FFFF; tick();
        bus.a2 = REG_PRID; tick();
        bus.a2 = 5'd3; tick();
        bus.a2 = REG_EPC; bus.din = 32'h1234_5677; tick();
        idle();
        push("wr_epc", REG_EPC, 32'h1234_5674);
        push("wr_cause_ro", REG_CAUSE, 32'h0);
        push("wr_prid_ro", REG_PRID, 32'h0000_0D00);
        push("wr_r3", 5'd3, 32'h0);
        push("wr_sr", REG_SR, 32'h0000_0401);
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus.a1 = e.addr; #1; n_cmp++;
            if (bus.dout !== e.val) begin
                n_err++; $display("FAIL %s: got %h expected %h", e.name, bus.dout, e.val);
            end
        end
        tick();
        bus.we = 1'b1; bus.a2 = REG_SR; bus.din = 32'hFFFF_FFFF; tick();
        idle();
        push("wr_sr_mask", REG_SR, 32'h0000_FC03);
        bus.exc_code = EXC_ADEL;
        #1; n_cmp++;
        if (bus.intreq !== 1'b0) begin
            n_err++; $display("FAIL exl_masks_exc: got %b expected 0", bus.intreq);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus.a1 = e.addr; #1; n_cmp++;
            if (bus.dout !== e.val) begin
                n_err++; $display("FAIL %s: got %h expected %h", e.name, bus.dout, e.val);
            end
        end
        idle();
        bus.we = 1'b1; bus.a2 = REG_SR; bus.din = 32'h0000_0401; tick();
        idle();
    endtask

    task automatic test_async_reset();
        sb_t e;
        bus.exc_code = EXC_ADES; bus.pc = 32'h0000_3100;
        #1; n_cmp++;
        if (bus.intreq !== 1'b1) begin
            n_err++; $display("FAIL ares_req: got %b expected 1", bus.intreq);
        end
        tick();
        idle();
        bus.a1 = REG_SR; #1; n_cmp++;
        if (bus.dout !== 32'h0000_0403) begin
            n_err++; $display("FAIL ares_pre_sr: got %h expected 00000403", bus.dout);
        end
        #1 reset = 1'b1;
        #1;
        push("ares_sr", REG_SR, 32'h0);
        push("ares_epc", REG_EPC, 32'h0);
        push("ares_cause", REG_CAUSE, 32'h0);
        n_cmp++;
        if (bus.intreq !== 1'b0) begin
            n_err++; $display("FAIL ares_intreq: got %b expected 0", bus.intreq);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus.a1 = e.addr; #1; n_cmp++;
            if (bus.dout !== e.val) begin
                n_err++; $display("FAIL %s: got %h expected %h", e.name, bus.dout, e.val);
            end
        end
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.a1 = '0; bus.pc = '0; bus.hw_int = '0;
        idle();
        #12;
        test_reset();
        tick();
        reset = 1'b0;
        tick();
        test_interrupt();
        test_exc_bd();
        test_collision();
        test_eret_pending();
        test_mtc0_filter();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
